// File: rtl/icache_dm_if.sv
// Fetch-side and refill-side signals of the direct-mapped instruction cache.
// The cache uses the slave modport; the core/memory environment uses master.
interface icache_dm_if;
  logic [31:0] pc;
  logic        flush;
  logic        hit;
  logic [31:0] instr;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [31:0] mem_rdata;
  logic        mem_ready;

  modport master (
    output pc,
    output flush,
    output mem_rdata,
    output mem_ready,
    input  hit,
    input  instr,
    input  mem_req,
    input  mem_addr
  );

  modport slave (
    input  pc,
    input  flush,
    input  mem_rdata,
    input  mem_ready,
    output hit,
    output instr,
    output mem_req,
    output mem_addr
  );
endinterface

// File: rtl/icache_dm.sv
// Direct-mapped instruction cache, 4-word lines, single outstanding line refill.
// Lookup is combinational in IDLE; a miss refills the whole line one beat at a time.
module icache_dm #(
  parameter int unsigned NLINES = 16
) (
  input logic        clk,
  input logic        rst,
  icache_dm_if.slave bus
);

  localparam int unsigned IdxW = $clog2(NLINES);
  localparam int unsigned TagW = 28 - IdxW;

  typedef enum logic {StIdle, StRefill} state_e;

  state_e            state_q, state_d;
  logic [1:0]        beat_q, beat_d;
  logic [27:0]       line_q, line_d;
  logic [NLINES-1:0] valid_q, valid_d;
  logic [TagW-1:0]   tag_q  [NLINES];
  logic [TagW-1:0]   tag_d  [NLINES];
  logic [31:0]       data_q [NLINES][4];
  logic [31:0]       data_d [NLINES][4];

  logic [IdxW-1:0] pc_idx;
  logic [TagW-1:0] pc_tag;
  logic [1:0]      pc_word;
  logic [IdxW-1:0] line_idx;
  logic [TagW-1:0] line_tag;
  logic            lookup_hit;

  assign pc_idx     = bus.pc[4 +: IdxW];
  assign pc_tag     = bus.pc[31 -: TagW];
  assign pc_word    = bus.pc[3:2];
  assign line_idx   = line_q[IdxW-1:0];
  assign line_tag   = line_q[27 -: TagW];
  assign lookup_hit = valid_q[pc_idx] && (tag_q[pc_idx] == pc_tag);

  always_comb begin
    state_d      = state_q;
    beat_d       = beat_q;
    line_d       = line_q;
    valid_d      = valid_q;
    tag_d        = tag_q;
    data_d       = data_q;
    bus.hit      = 1'b0;
    bus.instr    = 32'd0;
    bus.mem_req  = 1'b0;
    bus.mem_addr = 32'd0;

    unique case (state_q)
      StIdle: begin
        if (bus.flush) begin
          valid_d = '0;
        end else if (lookup_hit) begin
          bus.hit   = 1'b1;
          bus.instr = data_q[pc_idx][pc_word];
        end else begin
          line_d  = bus.pc[31:4];
          beat_d  = 2'd0;
          state_d = StRefill;
          // The victim line is dropped now so a half-written line can never hit.
          valid_d[pc_idx] = 1'b0;
        end
      end

      StRefill: begin
        bus.mem_req  = 1'b1;
        bus.mem_addr = {line_q, beat_q, 2'b00};
        if (bus.flush) begin
          // Abort: any beat accepted this cycle is thrown away.
          valid_d = '0;
          state_d = StIdle;
        end else if (bus.mem_ready) begin
          data_d[line_idx][beat_q] = bus.mem_rdata;
          beat_d = beat_q + 2'd1;
          if (beat_q == 2'd3) begin
            valid_d[line_idx] = 1'b1;
            tag_d[line_idx]   = line_tag;
            state_d           = StIdle;
          end
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      beat_q  <= 2'd0;
      line_q  <= 28'd0;
      valid_q <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      line_q  <= line_d;
      valid_q <= valid_d;
    end
  end

  // Tag and data arrays carry no reset; the valid bits gate every use of them.
  always_ff @(posedge clk) begin
    tag_q  <= tag_d;
    data_q <= data_d;
  end

endmodule

// File: tb/tb_icache_dm.sv
// Directed bench for icache_dm: cold miss, same-line hits, conflict eviction,
// stalled refill, flush (mid-refill and idle) and reset mid-refill.
module tb_icache_dm;

  logic clk;
  logic rst;
  int   errors;
  int   checks;

  icache_dm_if bus ();

  icache_dm #(.NLINES(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One refill beat: outputs must show the request, then the beat is accepted.
  task automatic beat(input string t, input logic [31:0] a, input logic [31:0] d);
    bus.mem_ready = 1'b1;
    bus.mem_rdata = d;
    #1;
    chk({t, " mem_req"}, {31'd0, bus.mem_req}, 32'd1);
    chk({t, " mem_addr"}, bus.mem_addr, a);
    chk({t, " hit"}, {31'd0, bus.hit}, 32'd0);
    chk({t, " instr"}, bus.instr, 32'd0);
    tick();
  endtask

  task automatic idle_hit(input string t, input logic [31:0] p, input logic [31:0] exp);
    bus.pc = p;
    #1;
    chk({t, " hit"}, {31'd0, bus.hit}, 32'd1);
    chk({t, " instr"}, bus.instr, exp);
    chk({t, " mem_req"}, {31'd0, bus.mem_req}, 32'd0);
  endtask

  task automatic idle_miss(input string t, input logic [31:0] p);
    bus.pc = p;
    #1;
    chk({t, " hit"}, {31'd0, bus.hit}, 32'd0);
    chk({t, " instr"}, bus.instr, 32'd0);
    chk({t, " mem_req"}, {31'd0, bus.mem_req}, 32'd0);
    chk({t, " mem_addr"}, bus.mem_addr, 32'd0);
  endtask

  initial begin
    errors        = 0;
    checks        = 0;
    rst           = 1'b1;
    bus.pc        = 32'd0;
    bus.flush     = 1'b0;
    bus.mem_ready = 1'b0;
    bus.mem_rdata = 32'd0;
    tick();
    tick();
    idle_miss("reset", 32'h0);
    rst = 1'b0;

    // Cold miss at 0x104
    idle_miss("cold detect", 32'h104);
    tick();
    beat("cold b0", 32'h100, 32'hA0);
    beat("cold b1", 32'h104, 32'hA1);
    beat("cold b2", 32'h108, 32'hA2);
    beat("cold b3", 32'h10C, 32'hA3);
    bus.mem_ready = 1'b0;
    idle_hit("cold hit", 32'h104, 32'hA1);
    idle_hit("line w0", 32'h100, 32'hA0);
    idle_hit("line w2", 32'h108, 32'hA2);
    idle_hit("line w3", 32'h10C, 32'hA3);

    // Conflict on index 0
    idle_miss("conflict detect", 32'h1104);
    tick();
    beat("conf b0", 32'h1100, 32'hB0);
    beat("conf b1", 32'h1104, 32'hB1);
    beat("conf b2", 32'h1108, 32'hB2);
    beat("conf b3", 32'h110C, 32'hB3);
    bus.mem_ready = 1'b0;
    idle_hit("conf hit", 32'h1104, 32'hB1);
    idle_miss("evicted", 32'h104);
    tick();

    // Stalled refill with pc wandering during the stall
    beat("stall b0", 32'h100, 32'hC0);
    bus.mem_ready = 1'b0;
    bus.pc        = 32'h3000;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("stall mem_req", {31'd0, bus.mem_req}, 32'd1);
      chk("stall mem_addr", bus.mem_addr, 32'h104);
      chk("stall hit", {31'd0, bus.hit}, 32'd0);
      tick();
    end
    bus.pc = 32'h104;
    beat("stall b1", 32'h104, 32'hC1);
    beat("stall b2", 32'h108, 32'hC2);
    beat("stall b3", 32'h10C, 32'hC3);
    bus.mem_ready = 1'b0;
    idle_hit("stall hit", 32'h104, 32'hC1);
    idle_hit("stall w3", 32'h10C, 32'hC3);

    // Flush after two beats
    idle_miss("fl detect", 32'h214);
    tick();
    beat("fl b0", 32'h210, 32'hD0);
    beat("fl b1", 32'h214, 32'hD1);
    bus.mem_ready = 1'b1;
    bus.mem_rdata = 32'hD2;
    bus.flush     = 1'b1;
    #1;
    chk("fl b2 mem_req", {31'd0, bus.mem_req}, 32'd1);
    chk("fl b2 mem_addr", bus.mem_addr, 32'h218);
    tick();
    bus.flush     = 1'b0;
    bus.mem_ready = 1'b0;
    idle_miss("fl cleared old", 32'h104);
    idle_miss("fl retry", 32'h214);
    tick();
    beat("re b0", 32'h210, 32'hE0);
    beat("re b1", 32'h214, 32'hE1);
    beat("re b2", 32'h218, 32'hE2);
    beat("re b3", 32'h21C, 32'hE3);
    bus.mem_ready = 1'b0;
    idle_hit("re hit", 32'h214, 32'hE1);
    idle_hit("re w2", 32'h218, 32'hE2);

    // Flush while idle on a valid line
    bus.pc    = 32'h214;
    bus.flush = 1'b1;
    #1;
    chk("idle flush hit", {31'd0, bus.hit}, 32'd0);
    chk("idle flush instr", bus.instr, 32'd0);
    tick();
    bus.flush = 1'b0;
    idle_miss("after idle flush", 32'h214);
    tick();
    beat("f b0", 32'h210, 32'hF0);
    beat("f b1", 32'h214, 32'hF1);
    beat("f b2", 32'h218, 32'hF2);
    beat("f b3", 32'h21C, 32'hF3);
    bus.mem_ready = 1'b0;
    idle_hit("f hit", 32'h214, 32'hF1);

    // Reset after one beat of a refill
    idle_miss("rs detect", 32'h324);
    tick();
    beat("rs b0", 32'h320, 32'h60);
    bus.mem_ready = 1'b1;
    bus.mem_rdata = 32'h61;
    rst           = 1'b1;
    #1;
    chk("rs b1 mem_addr", bus.mem_addr, 32'h324);
    tick();
    rst           = 1'b0;
    bus.mem_ready = 1'b0;
    idle_miss("rs after", 32'h324);
    idle_miss("rs old line", 32'h214);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
